// File: rtl/tracker_axis_ctrl.sv
// rtl/tracker_axis_ctrl.sv - multi-axis tracker motion controller
// Automatic mode follows sensor pairs on all axes; manual mode steps axes one at a time to target angles.
module tracker_axis_ctrl #(
  parameter int W        = 16,
  parameter int NAXES    = 2,
  parameter int MOD      = 360,
  parameter int DEADBAND = 4,
  parameter int SETTLE   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic               abort,
  input  logic [NAXES*W-1:0] sens_a,
  input  logic [NAXES*W-1:0] sens_b,
  input  logic [NAXES*W-1:0] ang_tgt,
  input  logic [NAXES*W-1:0] ang_cur,
  output logic [2*NAXES-1:0] dir,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int KW = (NAXES > 1) ? $clog2(NAXES) : 1;
  localparam logic [W:0]    DB    = (W+1)'(DEADBAND);
  localparam logic [W:0]    MODV  = (W+1)'(MOD);
  localparam logic [W:0]    HALF  = (W+1)'(MOD / 2);
  localparam logic [W-1:0]  MODW  = W'(MOD);
  localparam logic [CW-1:0] SET   = CW'(SETTLE);
  localparam logic [KW-1:0] KLAST = KW'(NAXES - 1);

  typedef enum logic [1:0] {S_IDLE, S_AUTO, S_MAN, S_FIN} state_t;

  state_t               r_state;
  logic [KW-1:0]        r_k;
  logic [CW-1:0]        r_cnt [NAXES];
  logic [2*NAXES-1:0]   r_dir;
  logic                 r_done;
  logic                 r_err;

  logic [NAXES-1:0]     w_auto_band;
  logic [NAXES-1:0]     w_auto_set;
  logic [2*NAXES-1:0]   w_auto_dir;
  logic [CW-1:0]        w_auto_cnt [NAXES];
  logic [W-1:0]         w_tgt [NAXES];
  logic [W-1:0]         w_cur [NAXES];

  for (genvar a = 0; a < NAXES; a++) begin : g_axis
    logic [W:0] w_e;
    logic [W:0] w_mag;
    assign w_e   = {1'b0, sens_a[a*W +: W]} - {1'b0, sens_b[a*W +: W]};
    assign w_mag = w_e[W] ? (~w_e + 1'b1) : w_e;
    assign w_auto_band[a]    = (w_mag <= DB);
    assign w_auto_dir[2*a +: 2] = w_auto_band[a] ? 2'b00 : (w_e[W] ? 2'b01 : 2'b10);
    assign w_auto_cnt[a] = !w_auto_band[a] ? '0 :
                           ((r_cnt[a] == SET) ? SET : r_cnt[a] + 1'b1);
    assign w_auto_set[a] = (w_auto_cnt[a] == SET);
    assign w_tgt[a] = ang_tgt[a*W +: W];
    assign w_cur[a] = ang_cur[a*W +: W];
  end

  logic [W-1:0]       w_tgt_k;
  logic [W-1:0]       w_cur_k;
  logic               w_range_err;
  logic [W:0]         w_diff;
  logic [W:0]         w_df;
  logic [W:0]         w_db;
  logic               w_man_band;
  logic [1:0]         w_man_step;
  logic [2*NAXES-1:0] w_man_dir;
  logic [CW-1:0]      w_man_cnt;

  assign w_tgt_k     = w_tgt[r_k];
  assign w_cur_k     = w_cur[r_k];
  assign w_range_err = (w_cur_k >= MODW) || (w_tgt_k >= MODW);
  // Negative raw difference wraps onto the circle so df is always the forward distance.
  assign w_diff      = {1'b0, w_tgt_k} - {1'b0, w_cur_k};
  assign w_df        = w_diff[W] ? (w_diff + MODV) : w_diff;
  assign w_db        = (w_df == '0) ? '0 : (MODV - w_df);
  assign w_man_band  = (w_df <= DB) || (w_db <= DB);
  assign w_man_step  = (w_df <= HALF) ? 2'b10 : 2'b01;
  assign w_man_dir   = (2*NAXES)'(w_man_step) << {r_k, 1'b0};
  assign w_man_cnt   = r_cnt[r_k] + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_dir   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int a = 0; a < NAXES; a++) r_cnt[a] <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_dir   <= '0;
      r_done  <= 1'b0;
      for (int a = 0; a < NAXES; a++) r_cnt[a] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dir  <= '0;
          r_done <= 1'b0;
          if (start) begin
            r_err   <= 1'b0;
            r_k     <= '0;
            r_state <= mode ? S_MAN : S_AUTO;
            for (int a = 0; a < NAXES; a++) r_cnt[a] <= '0;
          end
        end
        S_AUTO: begin
          r_dir  <= w_auto_dir;
          r_done <= &w_auto_set;
          for (int a = 0; a < NAXES; a++) r_cnt[a] <= w_auto_cnt[a];
        end
        S_MAN: begin
          r_done <= 1'b0;
          if (w_range_err) begin
            r_err   <= 1'b1;
            r_dir   <= '0;
            r_k     <= '0;
            r_state <= S_IDLE;
            for (int a = 0; a < NAXES; a++) r_cnt[a] <= '0;
          end else if (w_man_band) begin
            r_dir <= '0;
            if (w_man_cnt == SET) begin
              r_cnt[r_k] <= '0;
              if (r_k == KLAST) begin
                r_k     <= '0;
                r_done  <= 1'b1;
                r_state <= S_FIN;
              end else begin
                r_k <= r_k + 1'b1;
              end
            end else begin
              r_cnt[r_k] <= w_man_cnt;
            end
          end else begin
            r_dir      <= w_man_dir;
            r_cnt[r_k] <= '0;
          end
        end
        default: begin
          r_dir   <= '0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dir  = r_dir;
  assign done = r_done;
  assign err  = r_err;
  assign busy = (r_state == S_AUTO) || (r_state == S_MAN);

endmodule

// File: tb/tb_tracker_axis_ctrl.sv
// tb/tb_tracker_axis_ctrl.sv - directed bench for tracker_axis_ctrl
module tb_tracker_axis_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic        abort;
  logic [31:0] sens_a;
  logic [31:0] sens_b;
  logic [31:0] ang_tgt;
  logic [31:0] ang_cur;
  logic [3:0]  dir;
  logic        busy;
  logic        done;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  tracker_axis_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .sens_a(sens_a), .sens_b(sens_b), .ang_tgt(ang_tgt), .ang_cur(ang_cur),
    .dir(dir), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    sens_a = '0; sens_b = '0; ang_tgt = '0; ang_cur = '0;
    #12;
    chk("rst_dir", {28'd0, dir}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // AUTO: axis0 |e|=4 in band, axis1 e=0
    sens_a = {16'd50, 16'd100}; sens_b = {16'd50, 16'd104};
    start = 1'b1; mode = 1'b0;
    tick();
    chk("auto_busy", {31'd0, busy}, 32'd1);
    chk("auto_first_dir", {28'd0, dir}, 32'd0);
    start = 1'b0;
    tick();
    chk("auto_db_edge", {28'd0, dir}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("auto_not_settled", {31'd0, done}, 32'd0);
    tick();
    chk("auto_settled", {31'd0, done}, 32'd1);
    sens_b[15:0] = 16'd105;
    tick();
    chk("auto_dir_dec", {28'd0, dir}, 32'h1);
    chk("auto_done_drop", {31'd0, done}, 32'd0);
    sens_a = {16'd10, 16'd200}; sens_b = {16'd20, 16'd150};
    tick();
    chk("auto_dir_mix", {28'd0, dir}, 32'h6);

    // abort with start held
    abort = 1'b1; start = 1'b1;
    tick();
    chk("abort_auto_dir", {28'd0, dir}, 32'd0);
    chk("abort_auto_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("abort_start_held", {31'd0, busy}, 32'd0);
    abort = 1'b0; start = 1'b0;
    tick();

    // MAN wrap cases on axis0, axis1 at target
    ang_cur = {16'd0, 16'd350}; ang_tgt = {16'd0, 16'd10};
    start = 1'b1; mode = 1'b1;
    tick();
    chk("man_busy", {31'd0, busy}, 32'd1);
    chk("man_first_dir", {28'd0, dir}, 32'd0);
    start = 1'b0;
    tick();
    chk("man_wrap_inc", {28'd0, dir}, 32'h2);
    ang_cur[15:0] = 16'd10; ang_tgt[15:0] = 16'd350;
    tick();
    chk("man_wrap_dec", {28'd0, dir}, 32'h1);
    ang_cur[15:0] = 16'd0; ang_tgt[15:0] = 16'd180;
    tick();
    chk("man_tie", {28'd0, dir}, 32'h2);
    ang_cur[15:0] = 16'd358; ang_tgt[15:0] = 16'd1;
    ang_cur[31:16] = 16'd100; ang_tgt[31:16] = 16'd200;
    tick();
    chk("man_df3_band", {28'd0, dir}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("man_axis1_waits", {28'd0, dir}, 32'd0);
    tick();
    chk("man_axis0_settled_dir", {28'd0, dir}, 32'd0);
    chk("man_axis0_settled_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("man_axis1_moves", {28'd0, dir}, 32'h8);
    ang_cur[31:16] = 16'd200;
    tick();
    chk("man_axis1_band", {28'd0, dir}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("man_no_early_done", {31'd0, done}, 32'd0);
    tick();
    chk("man_done_pulse", {31'd0, done}, 32'd1);
    chk("man_busy_fall", {31'd0, busy}, 32'd0);
    tick();
    chk("man_done_one_cycle", {31'd0, done}, 32'd0);

    // range error
    ang_cur = {16'd0, 16'd0}; ang_tgt = {16'd0, 16'd360};
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("range_err", {31'd0, err}, 32'd1);
    chk("range_busy", {31'd0, busy}, 32'd0);
    chk("range_dir", {28'd0, dir}, 32'd0);
    tick();
    chk("range_no_done", {31'd0, done}, 32'd0);
    chk("range_err_sticky", {31'd0, err}, 32'd1);
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    chk("range_err_clear", {31'd0, err}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // abort mid-MAN
    ang_tgt = {16'd0, 16'd100};
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("man2_dir", {28'd0, dir}, 32'h2);
    abort = 1'b1;
    tick();
    chk("abort_man_dir", {28'd0, dir}, 32'd0);
    chk("abort_man_busy", {31'd0, busy}, 32'd0);
    abort = 1'b0;

    // asynchronous reset mid-move
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_dir", {28'd0, dir}, 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_dir", {28'd0, dir}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_err", {31'd0, err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tracker_axis_ctrl.md
# tracker_axis_ctrl

Parametrised multi-axis motion controller for the solar tracker. It drives NAXES motor direction pairs in one of two modes. In automatic mode it follows paired light-sensor readings. In manual mode it drives each axis to a target angle by the shortest path on a circular scale, one axis at a time. It sits between the sensor/angle acquisition logic and the motor drivers, and it adds dead-band settling, sequencing, abort and range-error reporting.

## Interface
- W, 16, width of each sensor and angle word (unsigned).
- NAXES, 2, number of axes; axis 0 is the vertical (teta) axis, axis 1 is the horizontal (fi) axis.
- MOD, 360, angle modulus; legal angles are 0..MOD-1; MOD < 2^W.
- DEADBAND, 4, allowed error magnitude counted as "on target" (inclusive).
- SETTLE, 8, consecutive in-band cycles needed to declare an axis settled (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle start request; sampled only in IDLE.
- mode  in  1  0 = automatic (sensor), 1 = manual (angle); latched on an accepted start.
- abort  in  1  return to IDLE at the next edge; has priority over every other input.
- sens_a, sens_b  in  NAXES*W  sensor pair per axis; axis k occupies bits [k*W +: W].
- ang_tgt, ang_cur  in  NAXES*W  target and current angle per axis, same packing.
- dir  out  2*NAXES  per-axis command at [2k +: 2]: 00 stop, 01 decrease/left, 10 increase/right; 11 is never driven.
- busy  out  1  high in AUTO or MAN.
- done  out  1  AUTO: level, all axes settled; MAN: one-cycle pulse when the sequence completes.
- err  out  1  sticky range error; cleared by an accepted start or by rst.

## Operation
- States: IDLE, AUTO, MAN, FIN.
- IDLE: start=1 goes to AUTO if mode=0, or to MAN with axis index k=0 if mode=1.
- AUTO, per axis every cycle:
  - e = sens_a − sens_b, signed W+1 bits.
  - |e| ≤ DEADBAND → 00; e<0 → 01; e>0 → 10.
  - Each axis has its own settle counter, saturating at SETTLE and cleared whenever the axis is out of band.
  - done = 1 while every counter equals SETTLE.
  - AUTO runs until abort.
- MAN, active axis k only; all other axes get 00:
  - If ang_cur[k] ≥ MOD or ang_tgt[k] ≥ MOD: set err, drive all dir to 00, go to IDLE. No done.
  - Forward distance df = (ang_tgt − ang_cur) in W+1 signed bits, plus MOD if negative; range 0..MOD-1. Backward distance db = MOD − df (take db = 0 when df = 0).
  - df ≤ DEADBAND or db ≤ DEADBAND → 00 and increment the settle counter; otherwise clear the counter.
  - Out of band: df ≤ MOD/2 (integer division) → 10, else 01. A tie at exactly MOD/2 goes to 10.
  - When the counter reaches SETTLE: clear the counter, then k = k+1. If k was NAXES-1, go to FIN instead.
- FIN: done=1 for one cycle, dir all 00, next state IDLE.
- abort in any state: next state IDLE, dir 00, counters cleared, done 0, err unchanged.
- start while not IDLE is ignored, as is any change of mode.

## Timing
- Reset values: state IDLE, dir all 0, busy 0, done 0, err 0, all counters 0, k 0.
- Accepted start at edge n: busy=1 after edge n. The first non-zero dir can appear after edge n+1, computed from the inputs sampled at edge n+1.
- dir, done and err are registered: each reflects the inputs sampled at the same edge, i.e. one-cycle latency.
- Settling: an axis that enters band at edge m is declared settled at edge m+SETTLE-1. In MAN, the next axis is evaluated from edge m+SETTLE.
- An axis that leaves band before its counter reaches SETTLE restarts counting from 0.
- Simultaneous start and abort in IDLE: abort wins and the state stays IDLE.
- Range error detected at edge n: err=1 and busy=0 after edge n.
- rst asserted mid-move: all outputs return to their reset values immediately, asynchronously.

## Test plan
1. Reset: assert rst during a MAN move → dir=0, busy=0, done=0, err=0 without waiting for a clock edge.
2. AUTO, W=16, DEADBAND=4:
   - axis0 a=100,b=104 → 00; a=100,b=105 → 01; a=200,b=150 → 10.
   - Hold all axes in band → done rises after SETTLE cycles.
   - Perturb one axis out of band → done drops the next cycle.
3. MAN wrap, MOD=360:
   - cur=350, tgt=10 → 10.
   - cur=10, tgt=350 → 01.
   - cur=0, tgt=180 → 10 (tie).
   - cur=358, tgt=1 → 00 (df=3).
4. MAN sequencing:
   - While axis0 is off target, dir[3:2]=00.
   - After axis0 has been in band for 8 cycles, axis1 starts moving.
   - When axis1 settles, done pulses for exactly one cycle and busy falls.
5. Range error: tgt0=360 → err=1, busy=0, no done. A following start clears err.
6. Abort: abort mid-AUTO and mid-MAN → IDLE at the next edge, dir=00. start held high during abort → no restart.
